par2ser_tx: RTL and testbench

PAR2SER_TX -- requirements
Module: par2ser_tx

---
 rtl/par2ser_pkg.sv | 20 ++
 rtl/par2ser_tx_bit_cell.sv | 35 +++
 rtl/par2ser_tx.sv | 136 +++++++++++++
 tb/tb_par2ser_tx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/par2ser_pkg.sv
// Shared types and constants for the parallel-to-serial transmitter.
// Optional parity state is present only when PAR2SER_PARITY_EN is defined.
package par2ser_pkg;

  localparam int DEFAULT_WIDTH = 8;

`ifdef PAR2SER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_e;
`endif

endpackage

// File: rtl/par2ser_tx_bit_cell.sv
// One shift-register stage: a single flop that either loads a
// parallel bit or takes its neighbour's bit, with sync reset.
module tx_bit_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sel_load,
  input  logic d_load,
  input  logic d_shift,
  output logic q
);

  logic q_q;
  logic q_d;

  // Pick the next stored bit: parallel load wins over shift.
  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = sel_load ? d_load : d_shift;
    end
  end

  // Storage flop with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/par2ser_tx.sv
// MSB-first parallel-to-serial transmitter with zero-gap streaming.
// Define PAR2SER_PARITY_EN to append an even-parity bit per word.
module par2ser_tx
  import par2ser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e          state_q;
  state_e          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sh_in;
  logic            last_bit;
  logic            accept;
  logic            sr_en;

`ifdef PAR2SER_PARITY_EN
  logic parity_q;
  logic parity_d;
`endif

  assign last_bit = (state_q == SHIFT) &&
                    (cnt_q == CW'(WIDTH - 1));

`ifdef PAR2SER_PARITY_EN
  assign done = (state_q == PARITY);
`else
  assign done = last_bit;
`endif

  assign ready  = (state_q == IDLE) || done;
  assign accept = load && ready;
  assign sr_en  = accept || (state_q == SHIFT);
  assign sh_in  = sr << 1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tx_bit_cell u_cell (
      .clk      (clk),
      .rst      (rst),
      .en       (sr_en),
      .sel_load (accept),
      .d_load   (in[i]),
      .d_shift  (sh_in[i]),
      .q        (sr[i])
    );
  end

  assign sout_valid = (state_q != IDLE);

`ifdef PAR2SER_PARITY_EN
  assign sout = (state_q == PARITY) ? parity_q
              : (sout_valid & sr[WIDTH-1]);
`else
  assign sout = sout_valid & sr[WIDTH-1];
`endif

  // Next state, bit counter and parity for the word in flight.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef PAR2SER_PARITY_EN
    parity_d = parity_q;
    if (accept) begin
      parity_d = ^in;
    end
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (last_bit) begin
`ifdef PAR2SER_PARITY_EN
          state_d = PARITY;
`else
          if (accept) begin
            cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef PAR2SER_PARITY_EN
      PARITY: begin
        if (accept) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM registers; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
`ifdef PAR2SER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef PAR2SER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_par2ser_tx.sv
// Bench for par2ser_tx: vector table plus corner-case sequences,
// checked cycle by cycle against a queue of expected outputs.
module tb_par2ser_tx;

`ifdef PAR2SER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  typedef struct packed {
    logic sout;
    logic valid;
    logic done;
    logic ready;
  } exp_t;

  typedef struct packed {
    logic [7:0] din;
    logic [7:0] ser;
    logic       par;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in;
  logic       load;
  logic       ready;
  logic       sout;
  logic       sout_valid;
  logic       done;

  exp_t  q[$];
  vec_t  tbl[7];
  int    n_chk = 0;
  int    n_fail = 0;
  string tag = "reset";

  par2ser_tx #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .load       (load),
    .ready      (ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic push_e(input logic s, input logic v,
                        input logic d, input logic r);
    exp_t e;
    e.sout  = s;
    e.valid = v;
    e.done  = d;
    e.ready = r;
    q.push_back(e);
  endtask

  task automatic push_idle();
    push_e(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic push_bits(input logic [7:0] ser, input logic par);
    logic last;
    for (int i = 0; i < 8; i++) begin
      last = (NB == 8) && (i == 7);
      push_e(ser[7-i], 1'b1, last, last);
    end
    if (NB == 9) push_e(par, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    n_chk++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expectation queued at t=%0t", tag, $time);
    end else begin
      e = q.pop_front();
      if ({sout, sout_valid, done, ready} !== e) begin
        n_fail++;
        $display("FAIL %s: got sout=%b valid=%b done=%b ready=%b, want sout=%b valid=%b done=%b ready=%b",
                 tag, sout, sout_valid, done, ready,
                 e.sout, e.valid, e.done, e.ready);
      end
    end
  endtask

  // Load a word at the current (ready) cycle, then run through its last bit.
  task automatic send(input logic [7:0] w, input logic [7:0] ser,
                      input logic par);
    in   = w;
    load = 1'b1;
    push_bits(ser, par);
    step();
    load = 1'b0;
    repeat (NB - 1) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;

    tbl[0] = '{din: 8'hA5, ser: 8'b1010_0101, par: 1'b0};
    tbl[1] = '{din: 8'h01, ser: 8'b0000_0001, par: 1'b1};
    tbl[2] = '{din: 8'h80, ser: 8'b1000_0000, par: 1'b1};
    tbl[3] = '{din: 8'h3C, ser: 8'b0011_1100, par: 1'b0};
    tbl[4] = '{din: 8'hFF, ser: 8'b1111_1111, par: 1'b0};
    tbl[5] = '{din: 8'h00, ser: 8'b0000_0000, par: 1'b0};
    tbl[6] = '{din: 8'h5A, ser: 8'b0101_1010, par: 1'b0};

    rst  = 1'b1;
    load = 1'b1;
    in   = 8'hFF;
    push_idle();
    step();
    load = 1'b0;
    push_idle();
    step();
    rst = 1'b0;
    push_idle();
    step();

    for (int k = 0; k < 7; k++) begin
      $sformat(tag, "vec%0d", k);
      send(tbl[k].din, tbl[k].ser, tbl[k].par);
      push_idle();
      step();
    end

    tag = "b2b";
    send(8'hFF, 8'hFF, 1'b0);
    send(8'h00, 8'h00, 1'b0);
    push_idle();
    step();

    tag = "busy";
    in   = 8'h3C;
    load = 1'b1;
    push_bits(8'h3C, 1'b0);
    step();
    load = 1'b0;
    step();
    step();
    in   = 8'hC3;
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (NB - 4) step();
    push_idle();
    step();
    push_idle();
    step();

    tag = "midrst";
    in   = 8'hF0;
    load = 1'b1;
    push_e(1'b1, 1'b1, 1'b0, 1'b0);
    push_e(1'b1, 1'b1, 1'b0, 1'b0);
    push_e(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    load = 1'b0;
    step();
    step();
    rst = 1'b1;
    push_idle();
    step();
    rst = 1'b0;
    push_idle();
    step();

    tag = "stream";
    for (int k = 0; k < 4; k++) begin
      w = 8'($urandom);
      send(w, w, ^w);
    end
    push_idle();
    step();

    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue: got %0d leftover, want 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
